// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - mode/state encodings and default widths for step_sequencer
package step_pkg;

    localparam int STEP_WIDTH_DEF = 4;
    localparam int WRAP_CNT_W_DEF = 16;

    localparam logic [1:0] MODE_WRAP_UP  = 2'b00;
    localparam logic [1:0] MODE_WRAP_DN  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_ONESHOT  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Only wrap-down starts its sequence descending.
    function automatic logic start_dir(input logic [1:0] m);
        return m != MODE_WRAP_DN;
    endfunction

endpackage

// File: rtl/step_next_calc.sv
// rtl/step_next_calc.sv - combinational next-step computation for one RUN tick
module step_next_calc
    import step_pkg::*;
#(
    parameter int WIDTH = STEP_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [WIDTH-1:0] active_steps,
    input  logic [1:0]       active_mode,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir,
    output logic             boundary,
    output logic             finish
);

    localparam logic [WIDTH-1:0] ONE = 1;

    // Only used in RUN, where active_steps is never zero.
    logic [WIDTH-1:0] last;
    assign last = active_steps - ONE;

    always_comb begin
        next_count = count;
        next_dir   = dir;
        boundary   = 1'b0;
        finish     = 1'b0;
        case (active_mode)
            MODE_WRAP_UP: begin
                next_dir = 1'b1;
                if (count == last) begin
                    boundary   = 1'b1;
                    next_count = '0;
                end else begin
                    next_count = count + ONE;
                end
            end
            MODE_WRAP_DN: begin
                next_dir = 1'b0;
                if (count == '0) begin
                    boundary   = 1'b1;
                    next_count = last;
                end else begin
                    next_count = count - ONE;
                end
            end
            MODE_PINGPONG: begin
                if (last == '0) begin
                    // Single-step ping-pong: every tick is a boundary.
                    boundary   = 1'b1;
                    next_count = '0;
                    next_dir   = 1'b1;
                end else if (dir) begin
                    if (count == last) begin
                        next_count = last - ONE;
                        next_dir   = 1'b0;
                    end else begin
                        next_count = count + ONE;
                    end
                end else begin
                    if (count == '0) begin
                        boundary   = 1'b1;
                        next_count = ONE;
                        next_dir   = 1'b1;
                    end else begin
                        next_count = count - ONE;
                    end
                end
            end
            default: begin
                next_dir = 1'b1;
                if (count == last) begin
                    finish = 1'b1;
                end else begin
                    next_count = count + ONE;
                end
            end
        endcase
    end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - multi-mode step index sequencer; STEP_SEQ_WRAP_CNT_EN adds wrap_cnt
module step_sequencer
    import step_pkg::*;
#(
    parameter int WIDTH      = STEP_WIDTH_DEF,
    parameter int WRAP_CNT_W = WRAP_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [WIDTH-1:0]      steps,
    input  logic [1:0]            mode,
    output logic [WIDTH-1:0]      count,
    output logic                  dir,
    output logic                  wrap,
    output logic                  done,
`ifdef STEP_SEQ_WRAP_CNT_EN
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
`endif
    output logic [WIDTH-1:0]      active_steps
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [1:0]       state;
    logic [1:0]       active_mode;
    logic [WIDTH-1:0] calc_count;
    logic             calc_dir;
    logic             boundary;
    logic             finish;
    logic             qualified;
    logic             from_pp;
    logic [WIDTH-1:0] start_count;
    logic             wrap_fire;

    step_next_calc #(.WIDTH(WIDTH)) u_next (
        .count        (count),
        .dir          (dir),
        .active_steps (active_steps),
        .active_mode  (active_mode),
        .next_count   (calc_count),
        .next_dir     (calc_dir),
        .boundary     (boundary),
        .finish       (finish)
    );

    assign qualified = tick & enable;
    assign wrap_fire = ~restart & qualified & (state == ST_RUN) & (boundary | finish);

    // A ping-pong sequence continuing past its 0 reversal resumes at 1;
    // a fresh start (from IDLE or another mode) begins at the mode's origin.
    assign from_pp = (state == ST_RUN) && (active_mode == MODE_PINGPONG);

    always_comb begin
        start_count = '0;
        case (mode)
            MODE_WRAP_DN:  start_count = (steps != '0) ? steps - ONE : '0;
            MODE_PINGPONG: start_count = (from_pp && steps > ONE) ? ONE : '0;
            default:       start_count = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            dir          <= 1'b1;
            wrap         <= 1'b0;
            done         <= 1'b0;
            active_steps <= '0;
            active_mode  <= MODE_WRAP_UP;
        end else begin
            wrap <= 1'b0;
            if (restart) begin
                state <= ST_IDLE;
                count <= '0;
                dir   <= 1'b1;
                done  <= 1'b0;
            end else if (qualified) begin
                case (state)
                    ST_IDLE: begin
                        if (steps != '0) begin
                            active_steps <= steps;
                            active_mode  <= mode;
                            state        <= ST_RUN;
                            count        <= start_count;
                            dir          <= start_dir(mode);
                        end
                    end
                    ST_RUN: begin
                        if (finish) begin
                            wrap  <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (boundary) begin
                            wrap         <= 1'b1;
                            active_steps <= steps;
                            active_mode  <= mode;
                            if (steps == '0) begin
                                state <= ST_IDLE;
                                count <= '0;
                                dir   <= 1'b1;
                            end else begin
                                count <= start_count;
                                dir   <= start_dir(mode);
                            end
                        end else begin
                            count <= calc_count;
                            dir   <= calc_dir;
                        end
                    end
                    ST_DONE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef STEP_SEQ_WRAP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_cnt <= '0;
        end else if (restart) begin
            wrap_cnt <= '0;
        end else if (wrap_fire && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`else
    logic unused_wrap_fire;
    assign unused_wrap_fire = wrap_fire;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - table-driven self-checking bench for step_sequencer
module tb_step_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       enable;
    logic       restart;
    logic [3:0] steps;
    logic [1:0] mode;
    logic [3:0] count;
    logic       dir;
    logic       wrap;
    logic       done;
    logic [3:0] active_steps;
`ifdef STEP_SEQ_WRAP_CNT_EN
    logic [15:0] wrap_cnt;
`endif

    step_sequencer #(.WIDTH(4), .WRAP_CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .enable       (enable),
        .restart      (restart),
        .steps        (steps),
        .mode         (mode),
        .count        (count),
        .dir          (dir),
        .wrap         (wrap),
        .done         (done),
`ifdef STEP_SEQ_WRAP_CNT_EN
        .wrap_cnt     (wrap_cnt),
`endif
        .active_steps (active_steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic       en;
        logic       rs;
        logic [3:0] st;
        logic [1:0] md;
        logic [3:0] cnt;
        logic       dr;
        logic       wr;
        logic       dn;
        logic [3:0] act;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic t, input logic e, input logic r,
                       input logic [3:0] s, input logic [1:0] m,
                       input logic [3:0] c, input logic d, input logic w,
                       input logic dn, input logic [3:0] a);
        vec_t v;
        v.tk = t; v.en = e; v.rs = r; v.st = s; v.md = m;
        v.cnt = c; v.dr = d; v.wr = w; v.dn = dn; v.act = a;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] c, input logic d,
                         input logic w, input logic dn, input logic [3:0] a);
        checks++;
        if (count !== c || dir !== d || wrap !== w || done !== dn || active_steps !== a) begin
            errors++;
            $display("FAIL %s: got count=%0d dir=%b wrap=%b done=%b act=%0d, want count=%0d dir=%b wrap=%b done=%b act=%0d",
                     name, count, dir, wrap, done, active_steps, c, d, w, dn, a);
        end
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; enable = 1'b1; restart = 1'b0; steps = 4'd0; mode = 2'b00;

        // wrap-up, N=5, twelve ticks
        add(1,1,0, 5,0, 0,1,0,0, 5);
        add(1,1,0, 5,0, 1,1,0,0, 5);
        add(1,1,0, 5,0, 2,1,0,0, 5);
        add(1,1,0, 5,0, 3,1,0,0, 5);
        add(1,1,0, 5,0, 4,1,0,0, 5);
        add(1,1,0, 5,0, 0,1,1,0, 5);
        add(1,1,0, 5,0, 1,1,0,0, 5);
        add(1,1,0, 5,0, 2,1,0,0, 5);
        add(1,1,0, 5,0, 3,1,0,0, 5);
        add(1,1,0, 5,0, 4,1,0,0, 5);
        add(1,1,0, 5,0, 0,1,1,0, 5);
        add(1,1,0, 5,0, 1,1,0,0, 5);
        add(0,1,1, 5,0, 0,1,0,0, 5);
        // wrap-down N=4, steps raised to 6 mid-sequence
        add(1,1,0, 4,1, 3,0,0,0, 4);
        add(1,1,0, 4,1, 2,0,0,0, 4);
        add(1,1,0, 6,1, 1,0,0,0, 4);
        add(1,1,0, 6,1, 0,0,0,0, 4);
        add(1,1,0, 6,1, 5,0,1,0, 6);
        add(1,1,0, 6,1, 4,0,0,0, 6);
        add(0,1,1, 6,1, 0,1,0,0, 6);
        // ping-pong N=4
        add(1,1,0, 4,2, 0,1,0,0, 4);
        add(1,1,0, 4,2, 1,1,0,0, 4);
        add(1,1,0, 4,2, 2,1,0,0, 4);
        add(1,1,0, 4,2, 3,1,0,0, 4);
        add(1,1,0, 4,2, 2,0,0,0, 4);
        add(1,1,0, 4,2, 1,0,0,0, 4);
        add(1,1,0, 4,2, 0,0,0,0, 4);
        add(1,1,0, 4,2, 1,1,1,0, 4);
        add(0,1,1, 4,2, 0,1,0,0, 4);
        // ping-pong N=1
        add(1,1,0, 1,2, 0,1,0,0, 1);
        add(1,1,0, 1,2, 0,1,1,0, 1);
        add(1,1,0, 1,2, 0,1,1,0, 1);
        add(0,1,0, 1,2, 0,1,0,0, 1);
        add(0,1,1, 1,2, 0,1,0,0, 1);
        // one-shot N=3, then ticks ignored in DONE
        add(1,1,0, 3,3, 0,1,0,0, 3);
        add(1,1,0, 3,3, 1,1,0,0, 3);
        add(1,1,0, 3,3, 2,1,0,0, 3);
        add(1,1,0, 3,3, 2,1,1,1, 3);
        for (int i = 0; i < 5; i++) add(1,1,0, 3,3, 2,1,0,1, 3);
        add(0,1,1, 3,3, 0,1,0,0, 3);
        // pause, then restart colliding with tick
        add(1,1,0, 5,0, 0,1,0,0, 5);
        add(1,1,0, 5,0, 1,1,0,0, 5);
        for (int i = 0; i < 3; i++) add(1,0,0, 5,0, 1,1,0,0, 5);
        add(1,1,0, 5,0, 2,1,0,0, 5);
        add(1,1,1, 5,0, 0,1,0,0, 5);
        add(1,1,0, 5,0, 0,1,0,0, 5);
        add(1,1,0, 5,0, 1,1,0,0, 5);
        // steps dropped to 0 mid-run: stop at next boundary
        add(1,1,0, 0,0, 2,1,0,0, 5);
        add(1,1,0, 0,0, 3,1,0,0, 5);
        add(1,1,0, 0,0, 4,1,0,0, 5);
        add(1,1,0, 0,0, 0,1,1,0, 0);
        add(1,1,0, 0,0, 0,1,0,0, 0);
        add(1,1,0, 0,0, 0,1,0,0, 0);
        // mode changed to wrap-down mid-run takes effect at the boundary
        add(1,1,0, 3,0, 0,1,0,0, 3);
        add(1,1,0, 3,1, 1,1,0,0, 3);
        add(1,1,0, 3,1, 2,1,0,0, 3);
        add(1,1,0, 3,1, 2,0,1,0, 3);
        add(1,1,0, 3,1, 1,0,0,0, 3);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            tick = vecs[i].tk; enable = vecs[i].en; restart = vecs[i].rs;
            steps = vecs[i].st; mode = vecs[i].md;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dr, vecs[i].wr, vecs[i].dn, vecs[i].act);
        end

        // asynchronous reset away from any clock edge
        tick = 1'b0; restart = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        tick = 1'b1; steps = 4'd2; mode = 2'b00;
        @(posedge clk);
        #1;
        check("after_reset_start", 4'd0, 1'b1, 1'b0, 1'b0, 4'd2);
        tick = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
